// File: rtl/cpu_addr_seq.sv
// Addressing-mode sequencer: fetches operand bytes at pc, indexes by X/Y, presents the effective address.
// Latency start->ea_valid: 2 (IMM/ZP), 3 (ZPX/ZPY/ABS/indexed no fix), 4 (indexed abs with page fix).
// ready=0 freezes all state and suppresses pc_inc; start is only accepted in IDLE/DONE with ready=1.
module cpu_addr_seq #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 16,
    parameter int ZP_WRAP = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ready,
    input  logic              start,
    input  logic [2:0]        mode,
    input  logic              is_write,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    input  logic [ADDR_W-1:0] pc,
    input  logic [DATA_W-1:0] d_in,
    output logic [ADDR_W-1:0] addr,
    output logic              pc_inc,
    output logic              busy,
    output logic              ea_valid,
    output logic [ADDR_W-1:0] ea
);

    if (ADDR_W != 2 * DATA_W) begin : g_width_check
        $error("cpu_addr_seq: ADDR_W must equal 2*DATA_W");
    end

    localparam logic [2:0] M_IMM  = 3'd0;
    localparam logic [2:0] M_ZP   = 3'd1;
    localparam logic [2:0] M_ZPX  = 3'd2;
    localparam logic [2:0] M_ZPY  = 3'd3;
    localparam logic [2:0] M_ABS  = 3'd4;
    localparam logic [2:0] M_ABSX = 3'd5;
    localparam logic [2:0] M_ABSY = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_OP1  = 3'd1,
        S_OP2  = 3'd2,
        S_IDX  = 3'd3,
        S_FIX  = 3'd4,
        S_DONE = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        mode_q, mode_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] adl_q, adl_d;
    logic [DATA_W-1:0] adh_q, adh_d;
    logic              cry_q, cry_d;
    logic [ADDR_W-1:0] ea_q, ea_d;
    logic [DATA_W:0]   sum;

    assign busy     = (state_q == S_OP1) || (state_q == S_OP2) ||
                      (state_q == S_IDX) || (state_q == S_FIX);
    assign ea_valid = (state_q == S_DONE);
    assign ea       = ea_q;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        wr_d    = wr_q;
        idx_d   = idx_q;
        adl_d   = adl_q;
        adh_d   = adh_q;
        cry_d   = cry_q;
        ea_d    = ea_q;
        addr    = pc;
        pc_inc  = 1'b0;
        sum     = {1'b0, adl_q} + {1'b0, idx_q};

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    mode_d = (mode == 3'd7) ? M_IMM : mode;
                    wr_d   = is_write;
                    case (mode)
                        M_ZPX, M_ABSX: idx_d = x;
                        M_ZPY, M_ABSY: idx_d = y;
                        default:       idx_d = '0;
                    endcase
                    state_d = S_OP1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_OP1: begin
                pc_inc = 1'b1;
                case (mode_q)
                    M_IMM: begin
                        ea_d    = pc;
                        state_d = S_DONE;
                    end
                    M_ZP: begin
                        ea_d    = ADDR_W'(d_in);
                        state_d = S_DONE;
                    end
                    M_ZPX, M_ZPY: begin
                        adl_d   = d_in;
                        state_d = S_IDX;
                    end
                    default: begin
                        adl_d   = d_in;
                        state_d = S_OP2;
                    end
                endcase
            end
            S_IDX: begin
                // dummy read of the unindexed zero-page address
                addr    = ADDR_W'(adl_q);
                ea_d    = (ZP_WRAP != 0) ? ADDR_W'(sum[DATA_W-1:0]) : ADDR_W'(sum);
                state_d = S_DONE;
            end
            S_OP2: begin
                pc_inc = 1'b1;
                adh_d  = d_in;
                adl_d  = sum[DATA_W-1:0];
                if ((mode_q == M_ABS) || (!sum[DATA_W] && !wr_q)) begin
                    ea_d    = {d_in, sum[DATA_W-1:0]};
                    state_d = S_DONE;
                end else begin
                    cry_d   = sum[DATA_W];
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                // stores always pay this cycle; the read goes to the un-carried high byte
                addr    = {adh_q, adl_q};
                ea_d    = {adh_q + DATA_W'(cry_q), adl_q};
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        if (!ready) begin
            state_d = state_q;
            mode_d  = mode_q;
            wr_d    = wr_q;
            idx_d   = idx_q;
            adl_d   = adl_q;
            adh_d   = adh_q;
            cry_d   = cry_q;
            ea_d    = ea_q;
            pc_inc  = 1'b0;
        end
        if (reset) begin
            pc_inc = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            mode_q  <= M_IMM;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            adl_q   <= '0;
            adh_q   <= '0;
            cry_q   <= 1'b0;
            ea_q    <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            adl_q   <= adl_d;
            adh_q   <= adh_d;
            cry_q   <= cry_d;
            ea_q    <= ea_d;
        end
    end

endmodule

// File: tb/tb_cpu_addr_seq.sv
// Bench for cpu_addr_seq: two instances (zero-page wrap on/off) sharing stimulus and a byte memory.
module tb_cpu_addr_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, ready, start, is_write;
    logic [2:0]  mode;
    logic [7:0]  x, y, d_in_a, d_in_b;
    logic [15:0] pc, addr_a, addr_b, ea_a, ea_b;
    logic        pc_inc_a, pc_inc_b, busy_a, busy_b, ea_valid_a, ea_valid_b;
    logic [7:0]  mem [0:65535];

    assign d_in_a = mem[addr_a];
    assign d_in_b = mem[addr_b];

    cpu_addr_seq #(.DATA_W(8), .ADDR_W(16), .ZP_WRAP(1)) dut_a (
        .clk(clk), .reset(reset), .ready(ready), .start(start), .mode(mode),
        .is_write(is_write), .x(x), .y(y), .pc(pc), .d_in(d_in_a),
        .addr(addr_a), .pc_inc(pc_inc_a), .busy(busy_a), .ea_valid(ea_valid_a), .ea(ea_a)
    );

    cpu_addr_seq #(.DATA_W(8), .ADDR_W(16), .ZP_WRAP(0)) dut_b (
        .clk(clk), .reset(reset), .ready(ready), .start(start), .mode(mode),
        .is_write(is_write), .x(x), .y(y), .pc(pc), .d_in(d_in_b),
        .addr(addr_b), .pc_inc(pc_inc_b), .busy(busy_b), .ea_valid(ea_valid_b), .ea(ea_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %04h expected %04h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: list of bus cycles (address, pc increment) and the resulting effective address.
    logic [15:0] exp_addr [4];
    logic        exp_inc  [4];
    int          exp_n;
    logic [15:0] exp_ea1, exp_ea0;

    task automatic model(input logic [2:0] m_in, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] xv, input logic [7:0] yv, input logic wr,
                         input logic [15:0] p);
        int m, idx, base;
        m   = (m_in == 3'd7) ? 0 : int'(m_in);
        idx = (m == 2 || m == 5) ? int'(xv) : (m == 3 || m == 6) ? int'(yv) : 0;
        exp_addr[0] = p;
        exp_inc[0]  = 1'b1;
        exp_n       = 1;
        case (m)
            0: begin
                exp_ea1 = p;
                exp_ea0 = p;
            end
            1: begin
                exp_ea1 = 16'(int'(b1));
                exp_ea0 = exp_ea1;
            end
            2, 3: begin
                exp_addr[1] = 16'(int'(b1));
                exp_inc[1]  = 1'b0;
                exp_n       = 2;
                exp_ea1     = 16'((int'(b1) + idx) % 256);
                exp_ea0     = 16'(int'(b1) + idx);
            end
            default: begin
                base        = int'(b2) * 256 + int'(b1);
                exp_addr[1] = p + 16'd1;
                exp_inc[1]  = 1'b1;
                exp_n       = 2;
                if ((int'(b1) + idx > 255) || (wr && m != 4)) begin
                    exp_addr[2] = 16'(int'(b2) * 256 + (int'(b1) + idx) % 256);
                    exp_inc[2]  = 1'b0;
                    exp_n       = 3;
                end
                exp_ea1 = 16'((base + idx) % 65536);
                exp_ea0 = exp_ea1;
            end
        endcase
    endtask

    // Entered just after a clock edge with the DUT in IDLE or DONE; leaves it mid-DONE.
    task automatic run_seq(input logic [2:0] m, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] xv, input logic [7:0] yv, input logic wr,
                           input logic [15:0] p, input int stall_at, input int stall_len,
                           output int lat);
        model(m, b1, b2, xv, yv, wr, p);
        pc = p;
        mem[p] = b1;
        mem[p + 16'd1] = b2;
        mode = m; x = xv; y = yv; is_write = wr; start = 1'b1; ready = 1'b1;
        @(posedge clk); #1;
        lat = 1;
        // latched inputs must be ignored from here on, including stray starts
        start = 1'($urandom); mode = 3'($urandom); x = 8'($urandom); y = 8'($urandom);
        is_write = 1'($urandom);
        for (int i = 0; i < exp_n; i++) begin
            if (i == stall_at) begin
                ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk);
                    chk16("stall_addr", addr_a, exp_addr[i]);
                    chk1("stall_pc_inc", pc_inc_a, 1'b0);
                    chk1("stall_busy", busy_a, 1'b1);
                    @(posedge clk); #1;
                    lat++;
                end
                ready = 1'b1;
            end
            @(negedge clk);
            chk16("bus_addr", addr_a, exp_addr[i]);
            chk16("bus_addr_b", addr_b, exp_addr[i]);
            chk1("pc_inc", pc_inc_a, exp_inc[i]);
            chk1("busy", busy_a, 1'b1);
            chk1("ea_valid_early", ea_valid_a, 1'b0);
            @(posedge clk); #1;
            lat++;
            if (exp_inc[i]) pc = pc + 16'd1;
        end
        start = 1'b0;
        @(negedge clk);
        chk1("ea_valid", ea_valid_a, 1'b1);
        chk1("ea_valid_b", ea_valid_b, 1'b1);
        chk1("done_busy", busy_a, 1'b0);
        chk1("done_pc_inc", pc_inc_a, 1'b0);
        chk16("done_addr", addr_a, pc);
        chk16("ea_wrap", ea_a, exp_ea1);
        chk16("ea_nowrap", ea_b, exp_ea0);
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk1("idle_ea_valid", ea_valid_a, 1'b0);
            chk1("idle_busy", busy_a, 1'b0);
            chk16("idle_ea_held", ea_a, exp_ea1);
        end
    endtask

    typedef struct {
        logic [2:0]  m;
        logic [7:0]  b1, b2, xv, yv;
        logic        wr;
        logic [15:0] p;
        logic [15:0] ea1, ea0;
        int          lat;
    } vec_t;

    vec_t vecs [11];
    int   lat, exp_lat, stall_at, stall_len;

    initial begin
        vecs[0]  = '{3'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 16'h8000, 16'h8000, 16'h8000, 2};
        vecs[1]  = '{3'd2, 8'hF0, 8'h00, 8'h20, 8'h00, 1'b0, 16'h8100, 16'h0010, 16'h0110, 3};
        vecs[2]  = '{3'd6, 8'h80, 8'h12, 8'h00, 8'h05, 1'b0, 16'h8200, 16'h1285, 16'h1285, 3};
        vecs[3]  = '{3'd6, 8'h80, 8'h12, 8'h00, 8'h05, 1'b1, 16'h8300, 16'h1285, 16'h1285, 4};
        vecs[4]  = '{3'd5, 8'hFF, 8'h12, 8'h01, 8'h00, 1'b0, 16'h8400, 16'h1300, 16'h1300, 4};
        vecs[5]  = '{3'd5, 8'hFF, 8'hFF, 8'h01, 8'h00, 1'b0, 16'h8500, 16'h0000, 16'h0000, 4};
        vecs[6]  = '{3'd1, 8'h42, 8'h00, 8'h00, 8'h00, 1'b0, 16'h8600, 16'h0042, 16'h0042, 2};
        vecs[7]  = '{3'd3, 8'h80, 8'h00, 8'h00, 8'h90, 1'b0, 16'h8700, 16'h0010, 16'h0110, 3};
        vecs[8]  = '{3'd4, 8'h34, 8'h12, 8'h07, 8'h09, 1'b1, 16'h8800, 16'h1234, 16'h1234, 3};
        vecs[9]  = '{3'd7, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 16'hC000, 16'hC000, 16'hC000, 2};
        vecs[10] = '{3'd5, 8'h10, 8'h20, 8'h05, 8'h00, 1'b0, 16'h8900, 16'h2015, 16'h2015, 3};

        for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 7 + 3);
        reset = 1'b1; ready = 1'b1; start = 1'b1; mode = 3'd4;
        x = 8'h00; y = 8'h00; is_write = 1'b0; pc = 16'h1234;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk1("rst_busy", busy_a, 1'b0);
        chk1("rst_ea_valid", ea_valid_a, 1'b0);
        chk1("rst_pc_inc", pc_inc_a, 1'b0);
        chk16("rst_ea", ea_a, 16'h0000);
        chk16("rst_addr", addr_a, pc);
        reset = 1'b0; start = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            run_seq(vecs[i].m, vecs[i].b1, vecs[i].b2, vecs[i].xv, vecs[i].yv, vecs[i].wr,
                    vecs[i].p, -1, 0, lat);
            chk16("vec_lat", 16'(lat), 16'(vecs[i].lat));
            chk16("vec_ea_wrap", ea_a, vecs[i].ea1);
            chk16("vec_ea_nowrap", ea_b, vecs[i].ea0);
            if (i % 2 == 1) idle(1);
        end

        // ready low for 3 cycles in OP2 stretches latency by exactly 3
        idle(1);
        run_seq(3'd6, 8'h80, 8'h12, 8'h00, 8'h05, 1'b0, 16'h9000, 1, 3, lat);
        chk16("stall_lat", 16'(lat), 16'd6);
        chk16("stall_ea", ea_a, 16'h1285);

        // start with ready low in IDLE is not accepted
        idle(1);
        ready = 1'b0; start = 1'b1; mode = 3'd4;
        @(posedge clk); #1;
        @(negedge clk);
        chk1("stalled_start_busy", busy_a, 1'b0);
        chk16("stalled_start_addr", addr_a, pc);
        ready = 1'b1; start = 1'b0;
        @(posedge clk); #1;

        // reset in FIX
        pc = 16'h0400; mem[16'h0400] = 8'hFF; mem[16'h0401] = 8'h12;
        mode = 3'd5; x = 8'h01; is_write = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        pc = pc + 16'd1;
        @(posedge clk); #1;
        pc = pc + 16'd1;
        @(negedge clk);
        chk16("fix_addr", addr_a, 16'h1200);
        chk1("fix_busy", busy_a, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk1("midrst_busy", busy_a, 1'b0);
        chk1("midrst_ea_valid", ea_valid_a, 1'b0);
        chk1("midrst_pc_inc", pc_inc_a, 1'b0);
        chk16("midrst_ea", ea_a, 16'h0000);
        chk16("midrst_ea_b", ea_b, 16'h0000);

        // reset beats a simultaneous start
        reset = 1'b1; start = 1'b1; mode = 3'd0;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        chk1("rst_start_busy", busy_a, 1'b0);
        @(posedge clk); #1;

        // back-to-back: ABS issued from DONE goes straight to OP1
        run_seq(3'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 16'hA000, -1, 0, lat);
        run_seq(3'd4, 8'hCD, 8'hAB, 8'h00, 8'h00, 1'b0, 16'hA001, -1, 0, lat);
        chk16("b2b_lat", 16'(lat), 16'd3);
        chk16("b2b_ea", ea_a, 16'hABCD);
        idle(2);

        for (int n = 0; n < 300; n++) begin
            logic [2:0]  rm;
            logic [7:0]  r1, r2, rx, ry;
            logic        rw;
            logic [15:0] rp;
            rm = 3'($urandom); r1 = 8'($urandom); r2 = 8'($urandom);
            rx = 8'($urandom); ry = 8'($urandom); rw = 1'($urandom); rp = 16'($urandom);
            stall_at  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1;
            stall_len = int'($urandom_range(1, 3));
            run_seq(rm, r1, r2, rx, ry, rw, rp, stall_at, stall_len, lat);
            exp_lat = 1 + exp_n + ((stall_at >= 0 && stall_at < exp_n) ? stall_len : 0);
            chk16("rand_lat", 16'(lat), 16'(exp_lat));
            idle(int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_addr_seq.md
Name: cpu_addr_seq

Overview:
- Parametrised addressing-mode sequencer for the NES 6502 core.
- Replaces the fixed ABS1/ABS2 path in the CPU controller.
- Accepts an addressing mode from decode, fetches operand bytes at PC, applies X/Y indexing with page-cross detection and a fix-up cycle, and presents the effective address (EA) to the execute stage.
- Drives the bus address and PC-increment request while active.

Parameters:
- DATA_W, 8: data bus and index register width.
- ADDR_W, 16: address width; must equal 2*DATA_W (elaboration error otherwise).
- ZP_WRAP, 1: 1 = zero-page indexed sum wraps within page 0 (6502); 0 = carry propagates into the high byte.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ready  in  1  bus ready; low stalls all state.
- start  in  1  begin sequence; sampled in IDLE or DONE.
- mode  in  3  0 IMM, 1 ZP, 2 ZPX, 3 ZPY, 4 ABS, 5 ABSX, 6 ABSY, 7 treated as IMM.
- is_write  in  1  store access: forces the indexed-absolute fix cycle.
- x  in  DATA_W  X index, latched at start.
- y  in  DATA_W  Y index, latched at start.
- pc  in  ADDR_W  current program counter.
- d_in  in  DATA_W  read data; valid in the same cycle as addr when ready=1.
- addr  out  ADDR_W  bus address.
- pc_inc  out  1  request PC+1 at the next edge.
- busy  out  1  sequence in progress.
- ea_valid  out  1  one-cycle pulse, ea valid.
- ea  out  ADDR_W  effective address, held until the next sequence.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values: state=IDLE, ea=0, ea_valid=0, busy=0, pc_inc=0, ADL/ADH/idx latches=0; addr=pc.
- States: IDLE, OP1, OP2, IDX, FIX, DONE.
- busy = (state is OP1, OP2, IDX or FIX). ea_valid = (state==DONE).
- Stall rule: with ready=0, state and latches hold and pc_inc=0. addr keeps its current value. No start is accepted.
- IDLE/DONE: addr=pc. If start && ready: latch mode, is_write and idx (x for ZPX/ABSX, y for ZPY/ABSY, else 0), then go to OP1. Otherwise DONE goes to IDLE.
- Back-to-back starts in DONE are legal and give zero gap.
- OP1: addr=pc, pc_inc=1.
  - IMM: ea<=pc, go to DONE.
  - ZP: ea<={0,d_in}, go to DONE.
  - ZPX/ZPY: ADL<=d_in, go to IDX.
  - ABS*: ADL<=d_in, go to OP2.
- IDX: addr={0,ADL} (dummy read), pc_inc=0. Then go to DONE.
  - ZP_WRAP=1: ea={0,(ADL+idx) mod 2^DATA_W}.
  - ZP_WRAP=0: ea=ADL+idx, zero-extended to ADDR_W.
- OP2: addr=pc, pc_inc=1. Compute {c,s}=ADL+idx, DATA_W+1 bits; ADH<=d_in, ADL<=s.
  - ABS, or c=0 && !is_write: ea<={d_in,s}, go to DONE.
  - Otherwise: save c, go to FIX.
- FIX: addr={ADH,ADL} (un-fixed dummy read), pc_inc=0. ea<={(ADH+c) mod 2^DATA_W, ADL}, go to DONE.
- Latency from the start edge to the ea_valid cycle:
  - 2 cycles: IMM, ZP.
  - 3 cycles: ZPX/ZPY, ABS, ABSX/ABSY without fix.
  - 4 cycles: ABSX/ABSY with fix.
- Wrap-around: EA arithmetic is modulo 2^ADDR_W, so $FFFF+1 gives $0000. PC wrap is owned by the PC register.
- start while busy: ignored.
- mode, x and y changes mid-sequence: no effect, because they are latched.
- Reset mid-sequence: IDLE at the next edge. No pc_inc or ea_valid that cycle. ea=0.
- reset and start in the same cycle: reset wins.

Test Plan:
- IMM at pc=$8000 -> OP1 addr=$8000, pc_inc=1; DONE ea=$8000, ea_valid for 1 cycle; total 2 cycles.
- ZPX, d_in=$F0, x=$20, ZP_WRAP=1 -> IDX addr=$00F0; ea=$0010. Rerun with ZP_WRAP=0 -> ea=$0110.
- ABSY, bytes $80,$12, y=$05, read -> no FIX; ea=$1285, 3 cycles. Same operands with is_write=1 -> FIX addr=$1285, ea=$1285, 4 cycles.
- ABSX, bytes $FF,$12, x=$01 -> FIX addr=$1200, ea=$1300. Operands $FF,$FF, x=$01 -> ea=$0000.
- ready low for 3 cycles during OP2 -> state and addr held, pc_inc=0 while low; ea and latency shift by exactly 3.
- reset asserted in FIX -> next cycle: busy=0, ea_valid=0, ea=0. start in DONE with mode ABS -> OP1 follows immediately.
